// File: rtl/axi4_aw_arbiter.sv
// axi4_aw_arbiter: N:1 AXI4 write-address arbiter with a single registered
// AW output slot and an ordered W-route FIFO that records which port won
// each accepted burst, so a downstream W mux can follow the AW order.
// Build option: define AXI4_AW_ARB_FIXED_PRIO_EN for fixed priority
// (lowest-indexed valid port wins, no round-robin pointer); otherwise
// round-robin arbitration is used.
// Handshake rule: a transfer happens on a channel in a cycle where both
// valid and ready are high at the rising clock edge; valid never waits
// for ready, and s_axi4_awready may depend combinationally on s_axi4_awvalid.
module axi4_aw_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4,
    parameter int ROUTE_DEPTH    = 4
) (
    input  logic                                axi4_aclk,
    input  logic                                axi4_arst,
    input  logic [NUM_PORTS-1:0]                s_axi4_awvalid,
    output logic [NUM_PORTS-1:0]                s_axi4_awready,
    input  logic [NUM_PORTS*AXI_ID_WIDTH-1:0]   s_axi4_awid,
    input  logic [NUM_PORTS*32-1:0]             s_axi4_awaddr,
    input  logic [NUM_PORTS*8-1:0]              s_axi4_awlen,
    input  logic [NUM_PORTS*3-1:0]              s_axi4_awsize,
    input  logic [NUM_PORTS*2-1:0]              s_axi4_awburst,
    input  logic [NUM_PORTS-1:0]                s_axi4_awlock,
    input  logic [NUM_PORTS*3-1:0]              s_axi4_awprot,
    input  logic [NUM_PORTS*4-1:0]              s_axi4_awcache,
    input  logic [NUM_PORTS*4-1:0]              s_axi4_awregion,
    input  logic [NUM_PORTS*4-1:0]              s_axi4_awqos,
    input  logic [NUM_PORTS*AXI_USER_WIDTH-1:0] s_axi4_awuser,
    output logic                                m_axi4_awvalid,
    input  logic                                m_axi4_awready,
    output logic [AXI_ID_WIDTH-1:0]             m_axi4_awid,
    output logic [31:0]                         m_axi4_awaddr,
    output logic [7:0]                          m_axi4_awlen,
    output logic [2:0]                          m_axi4_awsize,
    output logic [1:0]                          m_axi4_awburst,
    output logic                                m_axi4_awlock,
    output logic [2:0]                          m_axi4_awprot,
    output logic [3:0]                          m_axi4_awcache,
    output logic [3:0]                          m_axi4_awregion,
    output logic [3:0]                          m_axi4_awqos,
    output logic [AXI_USER_WIDTH-1:0]           m_axi4_awuser,
    output logic                                w_route_valid,
    output logic [$clog2(NUM_PORTS)-1:0]        w_route_port,
    input  logic                                w_route_ready
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(ROUTE_DEPTH);
    localparam int CW = AW + 1;

    logic          slot_free;
    logic          accept_en;
    logic          accept;
    logic          any_valid;
    logic          pop;
    logic [PW-1:0] winner;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] route_mem [ROUTE_DEPTH];

`ifndef AXI4_AW_ARB_FIXED_PRIO_EN
    logic [PW-1:0] rr_ptr;
`endif

    // Space is judged on the registered count only, so a pop in the same
    // cycle never makes room for a push; reset masks all readys.
    assign slot_free = !m_axi4_awvalid || m_axi4_awready;
    assign accept_en = !axi4_arst && slot_free && (count < CW'(ROUTE_DEPTH));
    assign accept    = accept_en && any_valid;
    assign pop       = w_route_valid && w_route_ready;

    // Winner search; scanning from the far end keeps the nearest hit.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            int idx;
`ifdef AXI4_AW_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(rr_ptr) + k) % NUM_PORTS;
`endif
            if (s_axi4_awvalid[idx]) begin
                any_valid = 1'b1;
                winner    = PW'(idx);
            end
        end
    end

    // Only the winner sees ready, and only when the slot and FIFO can take it.
    always_comb begin
        s_axi4_awready = '0;
        if (accept) s_axi4_awready[winner] = 1'b1;
    end

    // Registered AW slot: load on accept, drain on downstream ready.
    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            m_axi4_awvalid  <= 1'b0;
            m_axi4_awid     <= '0;
            m_axi4_awaddr   <= '0;
            m_axi4_awlen    <= '0;
            m_axi4_awsize   <= '0;
            m_axi4_awburst  <= '0;
            m_axi4_awlock   <= 1'b0;
            m_axi4_awprot   <= '0;
            m_axi4_awcache  <= '0;
            m_axi4_awregion <= '0;
            m_axi4_awqos    <= '0;
            m_axi4_awuser   <= '0;
        end else if (accept) begin
            m_axi4_awvalid  <= 1'b1;
            m_axi4_awid     <= s_axi4_awid[winner*AXI_ID_WIDTH +: AXI_ID_WIDTH];
            m_axi4_awaddr   <= s_axi4_awaddr[winner*32 +: 32];
            m_axi4_awlen    <= s_axi4_awlen[winner*8 +: 8];
            m_axi4_awsize   <= s_axi4_awsize[winner*3 +: 3];
            m_axi4_awburst  <= s_axi4_awburst[winner*2 +: 2];
            m_axi4_awlock   <= s_axi4_awlock[winner];
            m_axi4_awprot   <= s_axi4_awprot[winner*3 +: 3];
            m_axi4_awcache  <= s_axi4_awcache[winner*4 +: 4];
            m_axi4_awregion <= s_axi4_awregion[winner*4 +: 4];
            m_axi4_awqos    <= s_axi4_awqos[winner*4 +: 4];
            m_axi4_awuser   <= s_axi4_awuser[winner*AXI_USER_WIDTH +: AXI_USER_WIDTH];
        end else if (m_axi4_awready) begin
            m_axi4_awvalid  <= 1'b0;
        end
    end

`ifndef AXI4_AW_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves just past the port that was accepted.
    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + PW'(1);
        end
    end
`endif

    // Route FIFO pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)      count <= count + CW'(1);
            else if (!accept && pop) count <= count - CW'(1);
        end
    end

    // Route FIFO storage; contents are don't-care while unoccupied.
    always_ff @(posedge axi4_aclk) begin
        if (accept) route_mem[wr_ptr] <= winner;
    end

    assign w_route_valid = (count != '0);
    assign w_route_port  = w_route_valid ? route_mem[rd_ptr] : '0;

endmodule

// File: doc/axi4_aw_arbiter.md
AXI4_AW_ARBITER -- requirements
Module: axi4_aw_arbiter

Interface
REQ-001: Parameter NUM_PORTS, default 2, number of slave AW ports (2..4).
REQ-002: Parameter AXI_ID_WIDTH, default 4, AW ID width.
REQ-003: Parameter AXI_USER_WIDTH, default 4, AW user width.
REQ-004: Parameter ROUTE_DEPTH, default 4, W-route FIFO depth (power of two, >=2).
REQ-005: axi4_aclk  in  1  single clock; all logic SHALL be rising-edge.
REQ-006: axi4_arst  in  1  reset, synchronous and active-high.
REQ-007: s_axi4_awvalid / s_axi4_awready  in / out  NUM_PORTS  per-port AW handshake, bit i = port i.
REQ-008: s_axi4_awid, s_axi4_awaddr, s_axi4_awlen  in  NUM_PORTS x {AXI_ID_WIDTH, 32, 8}  packed per port, port i at slice i.
REQ-009: s_axi4_awsize/awburst/awlock/awprot/awcache/awregion/awqos/awuser  in  NUM_PORTS x {3,2,1,3,4,4,4,AXI_USER_WIDTH}  packed per port.
REQ-010: m_axi4_aw* (all fields above, single copy) plus m_axi4_awvalid  out; m_axi4_awready  in  1.
REQ-011: w_route_valid  out  1, w_route_port  out  clog2(NUM_PORTS), w_route_ready  in  1: ordered grant record for the W-channel mux.

Function
REQ-012: The block SHALL hold one registered AW output slot; latency from accepted s handshake to m_axi4_awvalid SHALL be exactly 1 cycle.
REQ-013: Slot free in a cycle = (!m_axi4_awvalid) || m_axi4_awready.
REQ-014: Accept enable = slot free && route FIFO count < ROUTE_DEPTH; a pop in the same cycle SHALL NOT free FIFO space for a push.
REQ-015: When accept enable, exactly one requesting port (winner) SHALL see s_axi4_awready=1; all others 0; with no valid input all readys 0.
REQ-016: Round-robin: search starts at rr_ptr and wraps modulo NUM_PORTS; after accepting port i, rr_ptr <= (i+1) mod NUM_PORTS; rr_ptr unchanged when nothing accepted.
REQ-017: On accept, the winner's fields SHALL load into the m slot and m_axi4_awvalid <= 1; the port index SHALL be pushed into the route FIFO in the same cycle.
REQ-018: m_axi4_aw* SHALL remain stable while m_axi4_awvalid=1 and m_axi4_awready=0.
REQ-019: m_axi4_awready with no accept SHALL clear m_axi4_awvalid next cycle; m_axi4_awready with accept SHALL keep it 1 with new data (back-to-back, one burst per cycle).
REQ-020: w_route_valid = FIFO not empty; w_route_port = oldest entry; pop on w_route_valid && w_route_ready.
REQ-021: w_route_ready with FIFO empty SHALL be ignored; count SHALL never underflow or exceed ROUTE_DEPTH; read/write pointers wrap modulo ROUTE_DEPTH.
REQ-022: FIFO full SHALL block all s_axi4_awready until a pop has been registered.
REQ-023: s_axi4_awready MAY depend combinationally on s_axi4_awvalid; no output SHALL depend combinationally on m_axi4_awready except s_axi4_awready.

Reset
REQ-024: While axi4_arst=1 at a clock edge: m_axi4_awvalid=0, all m_axi4_aw* data=0, rr_ptr=0, FIFO empty (w_route_valid=0, w_route_port=0).
REQ-025: All s_axi4_awready SHALL be 0 during reset cycles.
REQ-026: Reset mid-operation SHALL discard the held AW slot and all route entries without further handshakes.

Configuration
REQ-027: Macro AXI4_AW_ARB_FIXED_PRIO_EN defined: winner SHALL be lowest-indexed valid port, rr_ptr logic removed.
REQ-028: Macro undefined: round-robin per REQ-016; all other behaviour identical in both builds.

Verification
REQ-029: Reset, then port0 valid addr 0x1000 len 3, m_ready=1 -> s_ready0=1 same cycle, m_valid=1 with addr 0x1000 next cycle, route entry 0.
REQ-030: Both ports valid continuously, m_ready=1, w_route_ready=1 -> grants 0,1,0,1 on consecutive cycles; with FIXED_PRIO_EN, grants 0,0,0,0.
REQ-031: m_ready=0 for 5 cycles with slot loaded -> m_aw* unchanged, all s_ready=0, rr_ptr unchanged.
REQ-032: w_route_ready=0, ROUTE_DEPTH=4, 6 requests -> exactly 4 accepted, s_ready=0 thereafter; one pop -> next accept one cycle later, not the pop cycle.
REQ-033: axi4_arst pulsed 1 cycle with m_valid=1 and 3 route entries -> next cycle m_valid=0, w_route_valid=0, next grant from port 0.
